multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port OpCode, input, 6, IR[31:26] from the latched instruction register.
REQ-005 SHALL have port Funct, input, 6, IR[5:0].
REQ-006 SHALL have port mem_ready, input, 1, shared memory completes the current access this cycle.
REQ-007 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp, each 1 bit, datapath strobes/selects.
REQ-008 SHALL have outputs RegDst[1:0] (00 rd, 01 rt, 10 $31), MemtoReg[1:0] (00 ALUOut, 01 MDR, 10 PC), ALUSrcA[1:0] (00 PC, 01 rs, 10 shamt), ALUSrcB[1:0] (00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2), PCSource[1:0] (00 ALU, 01 ALUOut, 10 jump target, 11 rs).
REQ-009 SHALL have outputs ALUOp[1:0] (00 add, 01 sub, 10 decode Funct, 11 decode OpCode), state[2:0], retire (1, pulse), illegal_op (1, pulse), retired_cnt[RETIRE_W-1:0].

Function
REQ-010 SHALL implement Moore FSM states IF=0, ID=1, EX=2, MEM=3, WB=4; encodings 5-7 SHALL go to IF next cycle.
REQ-011 IF: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stay in IF while mem_ready=0, go ID when 1.
REQ-012 ID: ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); ExtOp=1.
REQ-013 ID, OpCode 0x02 (j): PCWrite=1, PCSource=10, retire, -> IF.
REQ-014 ID, OpCode 0x03 (jal): as j plus RegWrite=1, RegDst=10, MemtoReg=10, -> IF.
REQ-015 ID, OpCode 0x00 and Funct 0x08 (jr): PCWrite=1, PCSource=11, retire, -> IF; Funct 0x09 (jalr): also RegWrite=1, RegDst=00, MemtoReg=10.
REQ-016 ID, OpCode not in {0x00,0x02,0x03,0x04,0x08,0x09,0x0a,0x0b,0x0c,0x0f,0x23,0x2b}: illegal_op=1 one cycle, no write strobe, no retire, -> IF.
REQ-017 ID, any other legal opcode: -> EX.
REQ-018 EX R-type: ALUSrcA=10 when Funct in {0x00,0x02,0x03} else 01; ALUSrcB=00, ALUOp=10, -> WB.
REQ-019 EX lw/sw: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ExtOp=1, -> MEM.
REQ-020 EX beq: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retire, -> IF.
REQ-021 EX I-type ALU (0x08-0x0c, 0x0f): ALUSrcA=01, ALUSrcB=10, ALUOp=11; ExtOp=0 for 0x0c else 1; LuOp=1 only for 0x0f; -> WB.
REQ-022 MEM: IorD=1; lw MemRead=1, sw MemWrite=1; stay while mem_ready=0; lw -> WB; sw -> IF with retire on the mem_ready cycle.
REQ-023 WB: RegWrite=1 for exactly one cycle, retire; lw RegDst=01 MemtoReg=01; R-type RegDst=00 MemtoReg=00; I-type RegDst=01 MemtoReg=00; -> IF.
REQ-024 Any output not assigned in a state SHALL be 0.
REQ-025 retired_cnt SHALL increment by 1 on each cycle with retire=1, wrapping from all-ones to 0.
REQ-026 Cycles per instruction: j/jal/jr/jalr 2, beq 3, R/I-ALU 4, sw 4, lw 5, plus one per mem_ready=0 cycle.
REQ-027 OpCode/Funct SHALL be sampled only in ID, EX, MEM, WB (IR stable); never in IF.

Reset
REQ-028 While reset=1: state=IF, retired_cnt=0, and PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, retire, illegal_op forced 0.
REQ-029 Reset asserted mid-instruction SHALL abort it with no further write strobe; first cycle after release is IF.

Verification
REQ-030 reset, mem_ready=1, IR=lw (0x23) -> state 0,1,2,3,4,0; RegWrite=1 only in WB with RegDst=01 MemtoReg=01; retired_cnt=1.
REQ-031 IR=beq (0x04) -> states 0,1,2,0; PCWriteCond=1 PCSource=01 ALUOp=01 in EX; RegWrite never 1.
REQ-032 IR=jal (0x03) -> 2 cycles; in ID PCWrite=1 RegWrite=1 RegDst=10 MemtoReg=10.
REQ-033 mem_ready=0 for 3 cycles in IF then sw with mem_ready=0 for 2 cycles in MEM -> IRWrite only on the ready cycle; MemWrite held 3 MEM cycles; total 9 cycles.
REQ-034 IR OpCode=0x3f -> illegal_op pulse in ID, retired_cnt unchanged, back to IF.
REQ-035 reset pulse during MEM of sw -> MemWrite drops immediately, state=IF, retired_cnt=0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: a five-state Moore sequencer driving the
// shared-memory datapath strobes and selects, plus a counter of retired instructions.
module multi_cycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          OpCode,
    input  logic [5:0]          Funct,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ExtOp,
    output logic                LuOp,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUOp,
    output logic [2:0]          state,
    output logic                retire,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    state_t state_reg, state_next;
    logic [RETIRE_W-1:0] cnt_reg;

    logic pc_write_raw, pc_write_cond_raw, ir_write_raw, reg_write_raw;
    logic mem_write_raw, mem_read_raw, retire_raw, illegal_raw;

    // Opcode decode; only consulted outside IF, where the IR is stable.
    logic is_rtype, is_j, is_jal, is_jr, is_jalr, is_beq, is_lw, is_sw, is_itype, is_legal;
    assign is_rtype = (OpCode == 6'h00);
    assign is_j     = (OpCode == 6'h02);
    assign is_jal   = (OpCode == 6'h03);
    assign is_beq   = (OpCode == 6'h04);
    assign is_lw    = (OpCode == 6'h23);
    assign is_sw    = (OpCode == 6'h2b);
    assign is_jr    = is_rtype && (Funct == 6'h08);
    assign is_jalr  = is_rtype && (Funct == 6'h09);
    assign is_itype = ((OpCode >= 6'h08) && (OpCode <= 6'h0c)) || (OpCode == 6'h0f);
    assign is_legal = is_rtype || is_j || is_jal || is_beq || is_lw || is_sw || is_itype;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IF;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                cnt_reg <= cnt_reg + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_next        = ST_IF;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        ir_write_raw      = 1'b0;
        reg_write_raw     = 1'b0;
        mem_write_raw     = 1'b0;
        mem_read_raw      = 1'b0;
        retire_raw        = 1'b0;
        illegal_raw       = 1'b0;
        IorD              = 1'b0;
        ExtOp             = 1'b0;
        LuOp              = 1'b0;
        RegDst            = 2'b00;
        MemtoReg          = 2'b00;
        ALUSrcA           = 2'b00;
        ALUSrcB           = 2'b00;
        PCSource          = 2'b00;
        ALUOp             = 2'b00;
        case (state_reg)
            ST_IF: begin
                mem_read_raw = 1'b1;
                ALUSrcB      = 2'b01;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                state_next   = mem_ready ? ST_ID : ST_IF;
            end
            ST_ID: begin
                // Branch target is computed speculatively into ALUOut for a possible beq.
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                if (is_j || is_jal || is_jr || is_jalr) begin
                    pc_write_raw = 1'b1;
                    PCSource     = (is_jr || is_jalr) ? 2'b11 : 2'b10;
                    retire_raw   = 1'b1;
                    if (is_jal) begin
                        reg_write_raw = 1'b1;
                        RegDst        = 2'b10;
                        MemtoReg      = 2'b10;
                    end else if (is_jalr) begin
                        reg_write_raw = 1'b1;
                        RegDst        = 2'b00;
                        MemtoReg      = 2'b10;
                    end
                    state_next = ST_IF;
                end else if (!is_legal) begin
                    illegal_raw = 1'b1;
                    state_next  = ST_IF;
                end else begin
                    state_next = ST_EX;
                end
            end
            ST_EX: begin
                if (is_rtype) begin
                    ALUSrcA    = ((Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03))
                                 ? 2'b10 : 2'b01;
                    ALUOp      = 2'b10;
                    state_next = ST_WB;
                end else if (is_lw || is_sw) begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ExtOp      = 1'b1;
                    state_next = ST_MEM;
                end else if (is_beq) begin
                    ALUSrcA           = 2'b01;
                    ALUOp             = 2'b01;
                    pc_write_cond_raw = 1'b1;
                    PCSource          = 2'b01;
                    retire_raw        = 1'b1;
                end else if (is_itype) begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    ALUOp      = 2'b11;
                    ExtOp      = (OpCode != 6'h0c);
                    LuOp       = (OpCode == 6'h0f);
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                IorD = 1'b1;
                if (is_lw) begin
                    mem_read_raw = 1'b1;
                    state_next   = mem_ready ? ST_WB : ST_MEM;
                end else if (is_sw) begin
                    mem_write_raw = 1'b1;
                    retire_raw    = mem_ready;
                    state_next    = mem_ready ? ST_IF : ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                if (is_lw) begin
                    RegDst   = 2'b01;
                    MemtoReg = 2'b01;
                end else if (!is_rtype) begin
                    RegDst = 2'b01;
                end
            end
            default: state_next = ST_IF;
        endcase
    end

    // Write strobes and pulses are held off for the whole time reset is high.
    assign PCWrite     = pc_write_raw      & ~reset;
    assign PCWriteCond = pc_write_cond_raw & ~reset;
    assign IRWrite     = ir_write_raw      & ~reset;
    assign RegWrite    = reg_write_raw     & ~reset;
    assign MemWrite    = mem_write_raw     & ~reset;
    assign MemRead     = mem_read_raw      & ~reset;
    assign retire      = retire_raw        & ~reset;
    assign illegal_op  = illegal_raw       & ~reset;
    assign state       = state_reg;
    assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction table plus hand sequences,
// with per-instruction expectations queued on launch and compared on completion.
module tb_multi_cycle_ctrl;

    localparam int RW = 4;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] OpCode, Funct;
    logic mem_ready;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp;
    logic [2:0] state;
    logic retire, illegal_op;
    logic [RW-1:0] retired_cnt;

    multi_cycle_ctrl #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
        .LuOp(LuOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .state(state),
        .retire(retire), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         if_stall;
        int         mem_stall;
        int         cycles;
        int         retires;
        int         regwr;
        int         memwr;
        int         irwr;
        int         illegal;
        int         seq;
    } vec_t;

    typedef struct {
        string name;
        int    cycles;
        int    retires;
        int    regwr;
        int    memwr;
        int    irwr;
        int    illegal;
        int    seq;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];

    int total = 0;
    int passed = 0;
    int model_cnt = 0;

    // Observations from the last instruction run, with a per-state snapshot.
    int n_cyc, n_ret, n_rw, n_mw, n_ir, n_ill, seq_obs;
    logic [1:0] snap_regdst[5], snap_memtoreg[5], snap_pcsrc[5], snap_aluop[5], snap_srca[5];
    logic snap_pcwrite[5], snap_pcwc[5], snap_regwrite[5], snap_extop[5], snap_luop[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int ifs, mems, s;
        logic left;
        e.name = v.name; e.cycles = v.cycles; e.retires = v.retires; e.regwr = v.regwr;
        e.memwr = v.memwr; e.irwr = v.irwr; e.illegal = v.illegal; e.seq = v.seq;
        sb.push_back(e);
        OpCode = v.op; Funct = v.fn;
        n_cyc = 0; n_ret = 0; n_rw = 0; n_mw = 0; n_ir = 0; n_ill = 0; seq_obs = 0;
        ifs = 0; mems = 0; left = 1'b0;
        while (n_cyc < 30) begin
            if (state == 3'd0 && ifs < v.if_stall) begin mem_ready = 1'b0; ifs++; end
            else if (state == 3'd3 && mems < v.mem_stall) begin mem_ready = 1'b0; mems++; end
            else mem_ready = 1'b1;
            @(negedge clk);
            n_cyc++;
            seq_obs = (seq_obs << 3) | int'(state);
            n_ret += int'(retire); n_rw += int'(RegWrite); n_mw += int'(MemWrite);
            n_ir += int'(IRWrite); n_ill += int'(illegal_op);
            s = int'(state);
            if (s < 5) begin
                snap_regdst[s] = RegDst; snap_memtoreg[s] = MemtoReg; snap_pcsrc[s] = PCSource;
                snap_aluop[s] = ALUOp; snap_srca[s] = ALUSrcA; snap_pcwrite[s] = PCWrite;
                snap_pcwc[s] = PCWriteCond; snap_regwrite[s] = RegWrite;
                snap_extop[s] = ExtOp; snap_luop[s] = LuOp;
            end
            @(posedge clk); #1;
            if (state != 3'd0) left = 1'b1;
            else if (left) break;
        end
        e = sb.pop_front();
        model_cnt = (model_cnt + e.retires) % (1 << RW);
        chk({e.name, ".cycles"}, n_cyc, e.cycles);
        chk({e.name, ".states"}, seq_obs, e.seq);
        chk({e.name, ".retire"}, n_ret, e.retires);
        chk({e.name, ".regwrite"}, n_rw, e.regwr);
        chk({e.name, ".memwrite"}, n_mw, e.memwr);
        chk({e.name, ".irwrite"}, n_ir, e.irwr);
        chk({e.name, ".illegal"}, n_ill, e.illegal);
        chk({e.name, ".retired_cnt"}, int'(retired_cnt), model_cnt);
        $display("instr %s op=%02h fn=%02h cycles=%0d retired_cnt=%0d",
                 e.name, v.op, v.fn, n_cyc, retired_cnt);
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                input int ifs, input int ms, input int cyc, input int ret,
                                input int rw, input int mw, input int ill, input int sq);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.if_stall = ifs; v.mem_stall = ms;
        v.cycles = cyc; v.retires = ret; v.regwr = rw; v.memwr = mw; v.irwr = 1;
        v.illegal = ill; v.seq = sq;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk("add",      6'h00, 6'h20, 0, 0, 4, 1, 1, 0, 0, 'o0124);
        tbl[1]  = mk("sll",      6'h00, 6'h00, 0, 0, 4, 1, 1, 0, 0, 'o0124);
        tbl[2]  = mk("j",        6'h02, 6'h00, 0, 0, 2, 1, 0, 0, 0, 'o01);
        tbl[3]  = mk("jal",      6'h03, 6'h15, 0, 0, 2, 1, 1, 0, 0, 'o01);
        tbl[4]  = mk("jr",       6'h00, 6'h08, 0, 0, 2, 1, 0, 0, 0, 'o01);
        tbl[5]  = mk("jalr",     6'h00, 6'h09, 0, 0, 2, 1, 1, 0, 0, 'o01);
        tbl[6]  = mk("beq",      6'h04, 6'h00, 0, 0, 3, 1, 0, 0, 0, 'o012);
        tbl[7]  = mk("addi",     6'h08, 6'h00, 0, 0, 4, 1, 1, 0, 0, 'o0124);
        tbl[8]  = mk("andi",     6'h0c, 6'h00, 0, 0, 4, 1, 1, 0, 0, 'o0124);
        tbl[9]  = mk("op0d",     6'h0d, 6'h00, 0, 0, 2, 0, 0, 0, 1, 'o01);
        tbl[10] = mk("lui",      6'h0f, 6'h00, 0, 0, 4, 1, 1, 0, 0, 'o0124);
        tbl[11] = mk("lw",       6'h23, 6'h00, 0, 0, 5, 1, 1, 0, 0, 'o01234);
        tbl[12] = mk("sw",       6'h2b, 6'h00, 0, 0, 4, 1, 0, 1, 0, 'o0123);
        tbl[13] = mk("op3f",     6'h3f, 6'h00, 0, 0, 2, 0, 0, 0, 1, 'o01);
        tbl[14] = mk("sw_stall", 6'h2b, 6'h00, 3, 2, 9, 1, 0, 3, 0, 'o12333);
        tbl[15] = mk("lw_stall", 6'h23, 6'h00, 1, 1, 7, 1, 1, 0, 0, 'o12334);

        reset = 1'b1; mem_ready = 1'b0; OpCode = 6'h00; Funct = 6'h00;
        #1;
        chk("rst.state", int'(state), 0);
        chk("rst.retired_cnt", int'(retired_cnt), 0);
        chk("rst.memread", int'(MemRead), 0);
        chk("rst.strobes", int'({PCWrite, IRWrite, RegWrite, MemWrite, retire, illegal_op}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.state", int'(state), 0);

        run(tbl[11]);
        chk("lw.wb_regwrite", int'(snap_regwrite[4]), 1);
        chk("lw.wb_regdst", int'(snap_regdst[4]), 1);
        chk("lw.wb_memtoreg", int'(snap_memtoreg[4]), 1);
        run(tbl[6]);
        chk("beq.ex_pcwc", int'(snap_pcwc[2]), 1);
        chk("beq.ex_pcsrc", int'(snap_pcsrc[2]), 1);
        chk("beq.ex_aluop", int'(snap_aluop[2]), 1);
        run(tbl[3]);
        chk("jal.id_pcwrite", int'(snap_pcwrite[1]), 1);
        chk("jal.id_regwrite", int'(snap_regwrite[1]), 1);
        chk("jal.id_regdst", int'(snap_regdst[1]), 2);
        chk("jal.id_memtoreg", int'(snap_memtoreg[1]), 2);
        chk("jal.id_pcsrc", int'(snap_pcsrc[1]), 2);
        run(tbl[1]);
        chk("sll.ex_srca", int'(snap_srca[2]), 2);
        chk("sll.ex_aluop", int'(snap_aluop[2]), 2);
        run(tbl[10]);
        chk("lui.ex_luop", int'(snap_luop[2]), 1);
        chk("lui.ex_aluop", int'(snap_aluop[2]), 3);
        run(tbl[8]);
        chk("andi.ex_extop", int'(snap_extop[2]), 0);
        chk("andi.ex_luop", int'(snap_luop[2]), 0);

        // Full table; cumulative retires carry the 4-bit counter through its wrap.
        for (int i = 0; i < 16; i++) run(tbl[i]);

        // Reset landing in the MEM stall of a store.
        OpCode = 6'h2b; Funct = 6'h00; mem_ready = 1'b1;
        for (int k = 0; k < 10 && state != 3'd3; k++) begin
            @(posedge clk); #1;
        end
        chk("rstmem.reached_mem", int'(state), 3);
        mem_ready = 1'b0;
        #2;
        chk("rstmem.memwrite_before", int'(MemWrite), 1);
        reset = 1'b1;
        #1;
        model_cnt = 0;
        chk("rstmem.memwrite", int'(MemWrite), 0);
        chk("rstmem.state", int'(state), 0);
        chk("rstmem.retired_cnt", int'(retired_cnt), model_cnt);
        @(posedge clk); #1;
        chk("rstmem.hold_state", int'(state), 0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("rstmem.release_state", int'(state), 0);
        chk("rstmem.release_memread", int'(MemRead), 1);
        @(posedge clk); #1;
        run(tbl[2]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
